am2909_stack: RTL



---
 rtl/am2909_stack.sv | 79 +++++++
 1 files changed

// File: rtl/am2909_stack.sv
// Am2909 subroutine stack: LIFO of return addresses with a wrapping pointer,
// a saturating entry count and sticky overflow/underflow flags.
module am2909_stack #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PW    = $clog2(DEPTH)
) (
  input  logic             CP,
  input  logic             RST,
  input  logic             FE,
  input  logic             PUP,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] F,
  output logic [PW-1:0]    SP,
  output logic             EMPTY,
  output logic             FULL,
  output logic             OVF,
  output logic             UNF
);

  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  logic [WIDTH-1:0] file_q [DEPTH];
  logic [PW-1:0]    sp_q, sp_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             wr_en;
  logic             push, pop;

  assign push = !FE && PUP;
  assign pop  = !FE && !PUP;

  // Next-state: pointer wraps by truncation, count saturates at both ends.
  always_comb begin
    sp_d  = sp_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    wr_en = 1'b0;
    if (push) begin
      sp_d  = sp_q + PW'(1);
      wr_en = 1'b1;
      if (cnt_q == CNT_MAX) ovf_d = 1'b1;
      else                  cnt_d = cnt_q + CW'(1);
    end else if (pop) begin
      sp_d = sp_q - PW'(1);
      if (cnt_q == '0) unf_d = 1'b1;
      else             cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge CP) begin
    if (RST) begin
      for (int i = 0; i < int'(DEPTH); i++) file_q[i] <= '0;
      sp_q  <= '1;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      if (wr_en) file_q[sp_d] <= D;
    end
  end

  // Top of stack is read straight from the file so a return address is usable
  // in the same cycle the pop is requested.
  assign F     = file_q[sp_q];
  assign SP    = sp_q;
  assign EMPTY = (cnt_q == '0);
  assign FULL  = (cnt_q == CNT_MAX);
  assign OVF   = ovf_q;
  assign UNF   = unf_q;

endmodule
